// File: rtl/seq_detect_param.sv
// Serial pattern recognizer: compares the last PAT_LEN valid bits against a
// programmable pattern, emits a registered match pulse and a saturating count.
module seq_detect_param #(
  parameter int unsigned        PAT_LEN   = 3,
  parameter int unsigned        CNT_W     = 8,
  parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(3'b101)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inp,
  input  logic               inp_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] pattern
);

  localparam int unsigned       FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detect_param: PAT_LEN must be in 2..16");
  end

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] h_shift_c;
  logic [FILL_W-1:0]  f_inc_c;
  logic               hit_c;

  // Candidate history/fill for a sample this cycle, and whether it completes a match
  always_comb begin
    h_shift_c = {hist_q[PAT_LEN-2:0], inp};
    f_inc_c   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit_c     = inp_valid && !pat_load && (f_inc_c == FILL_FULL) && (h_shift_c == pattern_q);
  end

  // Next-state: a load discards any same-edge sample and restarts the history
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    match_d   = hit_c;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (inp_valid) begin
      hist_d = h_shift_c;
      fill_d = (hit_c && !overlap) ? '0 : f_inc_c;
    end

    // Clear beats a simultaneous hit; otherwise saturate instead of wrapping
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RESET_PAT;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign pattern   = pattern_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a 3-bit/8-bit instance and a
// 2-bit/2-bit instance share stimulus; a per-instance model predicts outputs.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inp, inp_valid, overlap, pat_load, cnt_clr;
  logic [2:0] pat_in;
  logic [1:0] pat_in_b;

  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] pat_a;
  logic [1:0] pat_b;

  assign pat_in_b = pat_in[1:0];

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(3), .CNT_W(8), .RESET_PAT(3'b101)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .inp(inp), .inp_valid(inp_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match_a), .match_cnt(cnt_a), .pattern(pat_a)
  );

  seq_detect_param #(.PAT_LEN(2), .CNT_W(2), .RESET_PAT(2'b11)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .inp(inp), .inp_valid(inp_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in_b), .cnt_clr(cnt_clr),
    .match(match_b), .match_cnt(cnt_b), .pattern(pat_b)
  );

  typedef struct {
    int ma; int ca; int pa;
    int mb; int cb; int pb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state, index 0 = instance A, 1 = instance B
  int m_hist[2], m_fill[2], m_pat[2], m_cnt[2], m_match[2];
  int m_len[2]  = '{3, 2};
  int m_cmax[2] = '{255, 3};
  int m_rpat[2] = '{5, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = 0; m_fill[k] = 0; m_pat[k] = m_rpat[k]; m_cnt[k] = 0; m_match[k] = 0;
    end
  endtask

  // Advance model by one edge using the currently driven inputs
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mask, h, f, hit;
      mask = (1 << m_len[k]) - 1;
      hit  = 0;
      if (pat_load) begin
        m_pat[k]  = int'(pat_in) & mask;
        m_hist[k] = 0;
        m_fill[k] = 0;
      end else if (inp_valid) begin
        h = ((m_hist[k] << 1) | int'(inp)) & mask;
        f = (m_fill[k] + 1 > m_len[k]) ? m_len[k] : m_fill[k] + 1;
        hit = (f == m_len[k] && h == m_pat[k]) ? 1 : 0;
        m_hist[k] = h;
        m_fill[k] = (hit != 0 && !overlap) ? 0 : f;
      end
      m_match[k] = hit;
      if (cnt_clr) m_cnt[k] = 0;
      else if (hit != 0 && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    check({tag, " sb_nonempty"}, int'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " A.match"},   int'(match_a), e.ma);
    check({tag, " A.cnt"},     int'(cnt_a),   e.ca);
    check({tag, " A.pattern"}, int'(pat_a),   e.pa);
    check({tag, " B.match"},   int'(match_b), e.mb);
    check({tag, " B.cnt"},     int'(cnt_b),   e.cb);
    check({tag, " B.pattern"}, int'(pat_b),   e.pb);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic cyc(input string tag, input logic v, input logic b, input logic ld,
                     input logic [2:0] pi, input logic clr);
    exp_t e;
    inp_valid = v; inp = b; pat_load = ld; pat_in = pi; cnt_clr = clr;
    model_step();
    e.ma = m_match[0]; e.ca = m_cnt[0]; e.pa = m_pat[0];
    e.mb = m_match[1]; e.cb = m_cnt[1]; e.pb = m_pat[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic bit_in(input string tag, input logic b);
    cyc(tag, 1'b1, b, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic reset_checked(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, " rst A.match"},   int'(match_a), 0);
    check({tag, " rst A.cnt"},     int'(cnt_a),   0);
    check({tag, " rst A.pattern"}, int'(pat_a),   5);
    check({tag, " rst B.match"},   int'(match_b), 0);
    check({tag, " rst B.cnt"},     int'(cnt_b),   0);
    check({tag, " rst B.pattern"}, int'(pat_b),   3);
    model_reset();
    inp = 1'b0; inp_valid = 1'b0; pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] stream = 5'b10101;

  initial begin
    rst_n = 1'b0; inp = 1'b0; inp_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;
    model_reset();
    #12;
    reset_checked("init");

    // Overlapping: 1,0,1,0,1 on 101 -> two hits
    overlap = 1'b1;
    for (int i = 4; i >= 0; i--) bit_in("ovl", stream[i]);
    idle("ovl_tail");
    check("ovl A.cnt final", int'(cnt_a), 2);

    // Non-overlapping: same stream -> one hit
    reset_checked("novl");
    overlap = 1'b0;
    for (int i = 4; i >= 0; i--) bit_in("novl", stream[i]);
    idle("novl_tail");
    check("novl A.cnt final", int'(cnt_a), 1);

    // Idle gaps do not break a partial pattern
    reset_checked("gap");
    overlap = 1'b1;
    bit_in("gap", 1'b1);
    repeat (3) idle("gap_idle");
    bit_in("gap", 1'b0);
    idle("gap_idle");
    bit_in("gap", 1'b1);
    check("gap A.match", int'(match_a), 1);
    idle("gap_tail");

    // Load 011 with a same-edge valid 1 (discarded), then 0,1,1
    cyc("load", 1'b1, 1'b1, 1'b1, 3'b011, 1'b0);
    bit_in("load", 1'b0);
    bit_in("load", 1'b1);
    bit_in("load", 1'b1);
    check("load A.match", int'(match_a), 1);
    check("load A.pattern", int'(pat_a), 3);
    idle("load_tail");

    // B: pattern 11, five valid 1s -> four pulses, count saturates at 3
    reset_checked("sat");
    overlap = 1'b1;
    repeat (5) bit_in("sat", 1'b1);
    check("sat B.cnt", int'(cnt_b), 3);
    // Clear on the same edge as a hit: pulse still seen, count cleared
    cyc("clr_hit", 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    check("clr_hit B.match", int'(match_b), 1);
    check("clr_hit B.cnt", int'(cnt_b), 0);
    idle("clr_tail");

    // Reset after 2 of 3 bits: next bit alone gives no match
    reset_checked("mid");
    bit_in("mid", 1'b1);
    bit_in("mid", 1'b0);
    reset_checked("mid2");
    bit_in("mid_after", 1'b1);
    check("mid_after A.match", int'(match_a), 0);

    // Reset asserted while a match pulse is high clears it at once
    reset_checked("pulse");
    bit_in("pulse", 1'b1);
    bit_in("pulse", 1'b0);
    bit_in("pulse", 1'b1);
    check("pulse A.match high", int'(match_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("pulse A.match async", int'(match_a), 0);
    check("pulse A.cnt async", int'(cnt_a), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic including loads, clears and mode changes
    for (int i = 0; i < 300; i++) begin
      overlap = 1'($urandom_range(0, 1));
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 39) == 0));
    end

    check("sb drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
